// File: rtl/alu_pipe_flags.sv
// Handshaked execute-stage ALU that owns the NZCV status register.
// Define ALU_MUL_EN to build the iterative multi-cycle multiply (cmd 1010).
module alu_pipe_flags #(
  parameter int WIDTH     = 32,
  parameter int MUL_CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cmd,
  input  logic             s_bit,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal,
  output logic [3:0]       flags
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
`ifdef ALU_MUL_EN
  localparam logic [3:0] CMD_MUL = 4'b1010;
`endif

  if (WIDTH < 4 || MUL_CNT_W < $clog2(WIDTH + 1)) begin : g_bad_param
    $error("alu_pipe_flags: WIDTH must be >= 4 and MUL_CNT_W must hold WIDTH");
  end

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;
  logic [3:0]       flags_q, flags_d;   // {N,Z,C,V}

`ifdef ALU_MUL_EN
  typedef enum logic {IDLE, MUL} state_e;
  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [WIDTH-1:0]       acc_q, acc_d;
  logic [MUL_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   s_q, s_d;
  logic [WIDTH-1:0]       acc_step;
  logic                   op_mul;
`endif

  logic [WIDTH-1:0] b_op;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] op_res;
  logic             op_legal;
  logic             op_arith;
  logic             op_v;
  logic             accept;

  function automatic logic [1:0] nz(input logic [WIDTH-1:0] r);
    return {r[WIDTH-1], r == '0};
  endfunction

  // Subtraction is v1 + ~v2 + cin, so one adder and one overflow rule cover all four ops.
  always_comb begin : alu_comb
    // NOTE: every output gets a default first so no path through the case infers a latch.
    b_op     = val2;
    cin      = 1'b0;
    op_res   = '0;
    op_legal = 1'b1;
    op_arith = 1'b0;
`ifdef ALU_MUL_EN
    op_mul   = 1'b0;
`endif
    case (cmd)
      CMD_MOV: op_res = val2;
      CMD_MVN: op_res = ~val2;
      CMD_ADD: op_arith = 1'b1;
      CMD_ADC: begin op_arith = 1'b1; cin = flags_q[1]; end
      CMD_SUB: begin op_arith = 1'b1; b_op = ~val2; cin = 1'b1; end
      CMD_SBC: begin op_arith = 1'b1; b_op = ~val2; cin = flags_q[1]; end
      CMD_AND: op_res = val1 & val2;
      CMD_ORR: op_res = val1 | val2;
      CMD_EOR: op_res = val1 ^ val2;
`ifdef ALU_MUL_EN
      CMD_MUL: op_mul = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
    sum = {1'b0, val1} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    if (op_arith) op_res = sum[WIDTH-1:0];
    op_v = (val1[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != val1[WIDTH-1]);
  end

`ifdef ALU_MUL_EN
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
`else
  assign in_ready = !out_valid_q || out_ready;
`endif
  assign accept = in_valid && in_ready;

  always_comb begin : next_comb
    out_valid_d = out_valid_q;
    result_d    = result_q;
    illegal_d   = illegal_q;
    flags_d     = flags_q;
`ifdef ALU_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept) begin
`ifdef ALU_MUL_EN
      if (op_mul) begin
        state_d  = MUL;
        mcand_d  = val1;
        mplier_d = val2;
        acc_d    = '0;
        cnt_d    = MUL_CNT_W'(WIDTH);
        s_d      = s_bit;
      end else
`endif
      begin
        out_valid_d = 1'b1;
        result_d    = op_legal ? op_res : '0;
        illegal_d   = !op_legal;
        if (op_legal && s_bit) begin
          flags_d[3:2] = nz(op_res);
          if (op_arith) flags_d[1:0] = {sum[WIDTH], op_v};
        end
      end
    end
`ifdef ALU_MUL_EN
    // Shift-and-add; the final iteration's sum is written straight to the result.
    if (state_q == MUL) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_step;
      cnt_d    = cnt_q - MUL_CNT_W'(1);
      if (cnt_q == MUL_CNT_W'(1)) begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        result_d    = acc_step;
        illegal_d   = 1'b0;
        if (s_q) flags_d[3:2] = nz(acc_step);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      flags_q     <= 4'b0000;
`ifdef ALU_MUL_EN
      state_q  <= IDLE;
      // NOTE: multiply datapath regs are reset only for clean X-free sim; state alone gates them.
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      s_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
      flags_q     <= flags_d;
`ifdef ALU_MUL_EN
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign illegal   = illegal_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe_flags.sv
// Directed-vector bench for alu_pipe_flags (WIDTH=32), covering both ALU_MUL_EN builds.
module tb_alu_pipe_flags;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cmd;
  logic        s_bit;
  logic [31:0] val1, val2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;
  logic [3:0]  flags;

  int pass_cnt  = 0;
  int total_cnt = 0;

  alu_pipe_flags #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cmd(cmd), .s_bit(s_bit), .val1(val1), .val2(val2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .illegal(illegal), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  cmd;
    logic        s;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] exp_res;
    logic        exp_ill;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Offer one op at the negedge, let it be accepted at the next posedge, sample #1 later.
  task automatic issue(input logic [3:0] c, input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    cmd = c; s_bit = s; val1 = a; val2 = b; in_valid = 1'b1;
    check("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int cycles;
    // cmd, s, v1, v2, result, illegal, {N,Z,C,V}
    vecs[0]  = '{4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 4'b1001};
    vecs[1]  = '{4'b0100, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 4'b1000};
    vecs[2]  = '{4'b0101, 1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0001, 1'b0, 4'b0010};
    vecs[3]  = '{4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 4'b0110};
    vecs[4]  = '{4'b0011, 1'b0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0006, 1'b0, 4'b0110};
    vecs[5]  = '{4'b1111, 1'b1, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 4'b0110};
    vecs[6]  = '{4'b0110, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 4'b1010};
    vecs[7]  = '{4'b0111, 1'b0, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 4'b1010};
    vecs[8]  = '{4'b1000, 1'b1, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 1'b0, 4'b0110};
    vecs[9]  = '{4'b1001, 1'b1, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 4'b1010};
    vecs[10] = '{4'b0100, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 4'b0011};
    vecs[11] = '{4'b0011, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'b0110};
    vecs[12] = '{4'b0101, 1'b1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 4'b1000};
    vecs[13] = '{4'b0101, 1'b1, 32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 1'b0, 4'b0010};
    vecs[14] = '{4'b0001, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'b0110};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cmd = 4'b0000; s_bit = 1'b0; val1 = '0; val2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {28'b0, flags}, 32'h0);
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_result", result, 32'h0);
    check("reset_illegal", {31'b0, illegal}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back single-cycle ops; flags chain from one vector to the next.
    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].cmd, vecs[i].s, vecs[i].v1, vecs[i].v2);
      check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      check($sformatf("vec%0d_illegal", i), {31'b0, illegal}, {31'b0, vecs[i].exp_ill});
      check($sformatf("vec%0d_flags", i), {28'b0, flags}, {28'b0, vecs[i].exp_flags});
    end

    // Backpressure: MOV held for three cycles, then MVN accepted with no bubble.
    issue(4'b0001, 1'b0, 32'h0, 32'h0000_00A5);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_result_held", result, 32'h0000_00A5);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    issue(4'b1001, 1'b0, 32'h0, 32'h0000_0000);
    check("bp_mvn_result", result, 32'hFFFF_FFFF);
    check("bp_mvn_out_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    check("drain_out_valid", {31'b0, out_valid}, 32'd0);
    check("drain_result_held", result, 32'hFFFF_FFFF);
    check("drain_flags", {28'b0, flags}, 32'h6);

    issue(4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
    check("pre_flags", {28'b0, flags}, 32'h9);

`ifdef ALU_MUL_EN
    issue(4'b1010, 1'b1, 32'h0001_0003, 32'h0002_0005);
    check("mul_accept_out_valid", {31'b0, out_valid}, 32'd0);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      if (cycles == 1) begin
        cmd = 4'b0010; s_bit = 1'b1; val1 = 32'h1; val2 = 32'h1; in_valid = 1'b1;
      end
      if (cycles == 5) begin
        check("mul_busy_in_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    check("mul_latency_edges", cycles, 32'd32);
    check("mul_result", result, 32'h000B_000F);
    check("mul_illegal", {31'b0, illegal}, 32'd0);
    check("mul_flags", {28'b0, flags}, 32'h1);

    issue(4'b1010, 1'b1, 32'h0000_0007, 32'h0000_0009);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mul_abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("mul_abort_flags", {28'b0, flags}, 32'h0);
    check("mul_abort_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mul_abort_idle_in_ready", {31'b0, in_ready}, 32'd1);
    check("mul_abort_stays_idle", {31'b0, out_valid}, 32'd0);
`else
    issue(4'b1010, 1'b1, 32'h0000_0007, 32'h0000_0009);
    check("mul_off_out_valid", {31'b0, out_valid}, 32'd1);
    check("mul_off_illegal", {31'b0, illegal}, 32'd1);
    check("mul_off_result", result, 32'h0);
    check("mul_off_flags", {28'b0, flags}, 32'h9);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_pipe_flags.md
Name: alu_pipe_flags

Overview:
- Parametrised, handshaked successor of the execute-stage ALU. Accepts one operation per transaction on a valid/ready interface, registers the result and holds it until it is consumed.
- Owns the architectural NZCV status register, with correct ARM carry/overflow semantics for every width. ADC/SBC read C from this register.
- Adds an iterative multi-cycle multiply.
- Sits between the EXE-stage operand muxes and the MEM-stage pipeline register.

Parameters:
- WIDTH, 32, datapath width in bits (≥4).
- MUL_CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation can be accepted this cycle
- cmd  in  4  exec command (encoding below)
- s_bit  in  1  update NZCV on completion
- val1  in  WIDTH  operand 1
- val2  in  WIDTH  operand 2
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- illegal  out  1  registered; the held result came from an undefined cmd
- flags  out  4  {N,Z,C,V} status register

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, out_valid=0, result=0, illegal=0, flags=4'b0000. Reset asserted mid-multiply aborts the operation and discards it.
- Command encoding:
  - 0001 MOV = val2
  - 1001 MVN = ~val2
  - 0010 ADD = v1+v2
  - 0011 ADC = v1+v2+C
  - 0100 SUB = v1-v2
  - 0101 SBC = v1-v2-!C
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - 1010 MUL = low WIDTH bits of v1*v2
  - All other codes are undefined.
- Transfer rules:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Output transfer occurs when out_valid && out_ready.
- Arithmetic is computed at WIDTH+1 bits.
  - ADD/ADC: C = bit WIDTH of the sum.
  - SUB/SBC: computed as v1 + ~v2 + cin, with cin=1 for SUB and cin=C for SBC. C = bit WIDTH, so C=1 means no borrow.
  - V (add): operand signs equal and result sign differs.
  - V (sub): operand signs differ and result sign differs from v1.
- Flag updates:
  - N = result[WIDTH-1] for every legal op.
  - Z = (result==0) for every legal op.
  - Logical ops, MOV, MVN and MUL leave C and V unchanged.
  - Flags are written on the completion edge only, and only when s_bit was set at accept. s_bit and cmd are latched at accept.
- Latency, single-cycle ops: accepted at edge k; result, illegal and flags are visible after edge k; out_valid=1 from k.
- Back-to-back operation: with out_ready held high, one op completes per cycle.
- ADC/SBC after a flag-setting op: ADC/SBC reads C from the register as updated by all previously completed ops. Consecutive back-to-back ops therefore see correct C with no hazard.
- Multiply state machine: IDLE → MUL → IDLE.
  - On accepting MUL: latch v1 and v2, clear the accumulator, set the counter to WIDTH, enter MUL. in_ready=0.
  - Each MUL cycle: if multiplier LSB is 1, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and decrement the counter.
  - When the counter reaches 0: write result, set out_valid=1, update flags if s_bit, return to IDLE.
  - Total latency is WIDTH+1 edges from accept to out_valid.
- Undefined cmd: result=0, illegal=1, flags untouched, latency 1.
- Output hold: while out_valid && !out_ready, result and illegal are held stable and no new accept occurs. in_ready=0 when blocked.
- Simultaneous output transfer and new accept in the same edge: the new result replaces the old one and out_valid stays 1.
- Output transfer with no new accept: out_valid falls to 0 and result holds its last value.
- Inputs are ignored while state==MUL.

Optional Feature:
- ALU_MUL_EN
  - Defined: cmd 1010 runs the iterative multiply described above.
  - Undefined: the MUL state and datapath are not built. 1010 is treated as an undefined command (result 0, illegal=1, latency 1, flags untouched).

Test Plan (WIDTH=32):
1. Reset and ADD overflow: hold rst_n=0, then release.
   - Reset: flags=0000, out_valid=0.
   - ADD 0x7FFFFFFF+0x00000001 with s_bit=1 → result 0x80000000, flags N=1 Z=0 C=0 V=1, out_valid after 1 edge.
2. SUB/SBC borrow chain: SUB 0x00000000-0x00000001 with s → 0xFFFFFFFF, N=1 C=0 V=0. Then SBC 5-3 with s → 0x00000001, C=1.
3. ADC carry-in: ADD 0xFFFFFFFF+1 with s → result 0, Z=1 C=1. Then ADC 2+3 with s_bit=0 → 0x00000006, flags still Z=1 C=1.
4. Backpressure: issue MOV 0xA5, hold out_ready=0 for 3 cycles.
   - in_ready=0 and result stays 0xA5 throughout.
   - Then out_ready=1 with in_valid carrying MVN 0 → result 0xFFFFFFFF on the next edge, with no bubble.
5. Multiply (ALU_MUL_EN defined): MUL 0x00010003 * 0x00020005 with s.
   - in_ready=0 for 32 cycles.
   - out_valid after 33 edges with result 0x000B000F, N=0 Z=0, C and V unchanged.
   - Assert rst_n=0 mid-multiply → out_valid=0, state IDLE.
6. Illegal and macro-off cases:
   - cmd 1111 → illegal=1, result 0, flags unchanged.
   - Without ALU_MUL_EN, cmd 1010 → illegal=1 after 1 edge.
